// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: NOP encoding, register-field positions and the next-PC select.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_HOLD,
    NPC_SEQ
  } npc_sel_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register between fetch and decode: reset/flush insert a bubble,
// a deasserted write enable holds every field including valid.
module if_id_reg #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                en,
  input  logic [31:0]         inst_d,
  input  logic [PC_WIDTH-1:0] pc4_d,
  output logic [31:0]         inst_q,
  output logic [PC_WIDTH-1:0] pc4_q,
  output logic                valid_q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, redirects on branch/jump and feeds the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                   PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter logic [31:0]          NOP_INST = NOP_INST_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_write,
  input  logic                if_id_write,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] inst_addr,
  input  logic [31:0]         inst_in,
  output logic [31:0]         if_id_inst,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic                if_id_valid,
  output logic [4:0]          if_id_rs,
  output logic [4:0]          if_id_rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  logic [PC_WIDTH-1:0] pc, pc4, pc_next;
  npc_sel_e            npc_sel;
  logic                redirect;

  assign pc4       = pc + PC_WIDTH'(4);
  assign inst_addr = pc;
  assign redirect  = branch_taken | jump;

  // Branch is older than the jump in ID, so it wins; either redirect beats a stall.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (rst)               npc_sel = NPC_RESET;
    else if (branch_taken) npc_sel = NPC_BRANCH;
    else if (jump)         npc_sel = NPC_JUMP;
    else if (!pc_write)    npc_sel = NPC_HOLD;
  end

  always_comb begin
    pc_next = pc4;
    case (npc_sel)
      NPC_RESET:  pc_next = RESET_PC;
      NPC_BRANCH: pc_next = branch_target;
      NPC_JUMP:   pc_next = jump_target;
      NPC_HOLD:   pc_next = pc;
      default:    pc_next = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    pc <= pc_next;
  end

  if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .en      (if_id_write),
    .inst_d  (inst_in),
    .pc4_d   (pc4),
    .inst_q  (if_id_inst),
    .pc4_q   (if_id_pc4),
    .valid_q (if_id_valid)
  );

  assign if_id_rs = if_id_inst[RS_MSB:RS_LSB];
  assign if_id_rt = if_id_inst[RT_MSB:RT_LSB];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && !redirect && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
